// File: rtl/usb_pkg.sv
// Shared USB constants: request codes, PIDs, CRC16 and line states.
// STALL support is gated by the USB_TX_STALL_EN macro.
package usb_pkg;

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_DATA0 = 3'd1,
    PKT_DATA1 = 3'd2,
    PKT_ACK   = 3'd3,
    PKT_NAK   = 3'd4,
    PKT_STALL = 3'd5
  } tx_pkt_e;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP_SE0, S_EOP_J
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  // x^16+x^15+x^2+1, bit-reversed for LSB-first shifting
  localparam logic [15:0] CRC16_POLY_REV = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;

  typedef logic [1:0] line_t;   // {d_plus, d_minus}
  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  localparam logic [2:0] STUFF_RUN = 3'd6;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    crc16_step = {1'b0, crc[15:1]} ^ (fb ? CRC16_POLY_REV : 16'h0000);
  endfunction

  function automatic logic req_valid(input logic [2:0] code);
    req_valid = 1'b0;
    case (code)
      PKT_DATA0, PKT_DATA1, PKT_ACK, PKT_NAK: req_valid = 1'b1;
`ifdef USB_TX_STALL_EN
      PKT_STALL: req_valid = 1'b1;
`endif
      default: req_valid = 1'b0;
    endcase
  endfunction

  function automatic logic is_data_code(input logic [2:0] code);
    is_data_code = (code == PKT_DATA0) || (code == PKT_DATA1);
  endfunction

  function automatic logic [7:0] pid_byte(input logic [2:0] code);
    pid_byte = 8'h00;
    case (code)
      PKT_DATA0: pid_byte = PID_DATA0;
      PKT_DATA1: pid_byte = PID_DATA1;
      PKT_ACK:   pid_byte = PID_ACK;
      PKT_NAK:   pid_byte = PID_NAK;
`ifdef USB_TX_STALL_EN
      PKT_STALL: pid_byte = PID_STALL;
`endif
      default:   pid_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_encoder.sv
// Line encoder: bit timer, bit stuffing and NRZI driver for d_plus/d_minus.
// A bit is taken at each bit boundary; bit_strobe is low when a stuff bit goes out instead.
module usb_tx_encoder
  import usb_pkg::*;
#(
  parameter int BIT_CLKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic bit_in,
  input  logic stuff_en,
  input  logic se0,
  input  logic force_j,
  output logic bit_strobe,
  output logic busy,
  output logic d_plus,
  output logic d_minus
);

  localparam int TW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

  logic [TW-1:0] timer;
  logic [2:0]    ones;
  logic          level;   // 1 = J
  line_t         lines;
  logic          timer_last, load, stuff, nrzi;

  assign timer_last = (timer == TW'(BIT_CLKS - 1));
  assign load       = bit_valid && (!busy || timer_last);
  // A pending stuff bit wins over whatever is offered, including EOP.
  assign stuff      = (ones == STUFF_RUN);
  assign bit_strobe = load && !stuff;
  assign nrzi       = bit_in ? level : ~level;
  assign {d_plus, d_minus} = lines;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      busy  <= 1'b0;
      ones  <= 3'd0;
      level <= 1'b1;
      lines <= LINE_J;
    end else if (load) begin
      timer <= '0;
      busy  <= 1'b1;
      if (stuff) begin
        level <= ~level;
        lines <= level ? LINE_K : LINE_J;
        ones  <= 3'd0;
      end else if (se0) begin
        lines <= LINE_SE0;
        ones  <= 3'd0;
      end else if (force_j) begin
        level <= 1'b1;
        lines <= LINE_J;
        ones  <= 3'd0;
      end else begin
        level <= nrzi;
        lines <= nrzi ? LINE_J : LINE_K;
        ones  <= (stuff_en && bit_in) ? ones + 3'd1 : 3'd0;
      end
    end else if (busy) begin
      if (timer_last) begin
        busy  <= 1'b0;
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: SYNC, PID, payload, CRC16, EOP.
// Define USB_TX_STALL_EN to accept request code 5 (STALL handshake).
module usb_tx
  import usb_pkg::*;
#(
  parameter int BIT_CLKS  = 8,
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_transfer_active,
  output logic       tx_error
);

  tx_state_e   state, state_n;
  logic [15:0] shreg, shreg_n, crc, crc_n, crc_bit;
  logic [3:0]  idx, idx_n;
  logic [6:0]  cnt, cnt_n, occ_clamped;
  logic [2:0]  code, code_n;
  logic        bit_valid, bit_in, stuff_en, se0, force_j;
  logic        bit_strobe, enc_busy;
  logic        active, is_data, accept, reject;

  // The encoder stays busy through the final J bit after the FSM is back in IDLE.
  assign active             = (state != S_IDLE) || enc_busy;
  assign tx_transfer_active = active;
  assign is_data            = is_data_code(code);
  assign accept             = !active && req_valid(tx_packet);
  assign reject             = (tx_packet != 3'd0) && (active || !req_valid(tx_packet));
  assign occ_clamped        = (buffer_occupancy > 7'(MAX_BYTES)) ? 7'(MAX_BYTES)
                                                                 : buffer_occupancy;
  assign crc_bit            = crc16_step(crc, shreg[0]);

  always_comb begin
    state_n            = state;
    shreg_n            = shreg;
    idx_n              = idx;
    cnt_n              = cnt;
    crc_n              = crc;
    code_n             = code;
    get_tx_packet_data = 1'b0;
    bit_valid          = 1'b1;
    bit_in             = shreg[0];
    stuff_en           = 1'b1;
    se0                = 1'b0;
    force_j            = 1'b0;
    case (state)
      S_IDLE: begin
        // First SYNC bit is offered straight from the request so it hits the line next cycle.
        bit_valid = accept;
        bit_in    = SYNC_BYTE[0];
        stuff_en  = 1'b0;
        if (accept) begin
          state_n = S_SYNC;
          shreg_n = {9'h000, SYNC_BYTE[7:1]};
          idx_n   = 4'd1;
          code_n  = tx_packet;
          cnt_n   = is_data_code(tx_packet) ? occ_clamped : 7'd0;
        end
      end
      S_SYNC: begin
        stuff_en = 1'b0;
        if (bit_strobe) begin
          if (idx == 4'd7) begin
            state_n = S_PID;
            shreg_n = {8'h00, pid_byte(code)};
            idx_n   = 4'd0;
          end else begin
            shreg_n = {1'b0, shreg[15:1]};
            idx_n   = idx + 4'd1;
          end
        end
      end
      S_PID: begin
        if (bit_strobe) begin
          if (idx == 4'd7) begin
            idx_n = 4'd0;
            crc_n = CRC16_INIT;
            if (!is_data) begin
              state_n = S_EOP_SE0;
            end else if (cnt != 7'd0) begin
              state_n            = S_DATA;
              shreg_n            = {8'h00, tx_packet_data};
              get_tx_packet_data = 1'b1;
              cnt_n              = cnt - 7'd1;
            end else begin
              state_n = S_CRC;
              shreg_n = ~CRC16_INIT;
            end
          end else begin
            shreg_n = {1'b0, shreg[15:1]};
            idx_n   = idx + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (bit_strobe) begin
          crc_n = crc_bit;
          if (idx == 4'd7) begin
            idx_n = 4'd0;
            if (cnt != 7'd0) begin
              shreg_n            = {8'h00, tx_packet_data};
              get_tx_packet_data = 1'b1;
              cnt_n              = cnt - 7'd1;
            end else begin
              state_n = S_CRC;
              shreg_n = ~crc_bit;
            end
          end else begin
            shreg_n = {1'b0, shreg[15:1]};
            idx_n   = idx + 4'd1;
          end
        end
      end
      S_CRC: begin
        if (bit_strobe) begin
          if (idx == 4'd15) begin
            state_n = S_EOP_SE0;
            idx_n   = 4'd0;
          end else begin
            shreg_n = {1'b0, shreg[15:1]};
            idx_n   = idx + 4'd1;
          end
        end
      end
      S_EOP_SE0: begin
        se0 = 1'b1;
        if (bit_strobe) begin
          if (idx == 4'd1) begin
            state_n = S_EOP_J;
            idx_n   = 4'd0;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      S_EOP_J: begin
        force_j = 1'b1;
        if (bit_strobe) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= 16'h0000;
      idx      <= 4'd0;
      cnt      <= 7'd0;
      crc      <= 16'h0000;
      code     <= 3'd0;
      tx_error <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      crc      <= crc_n;
      code     <= code_n;
      tx_error <= reject;
    end
  end

  usb_tx_encoder #(.BIT_CLKS(BIT_CLKS)) u_enc (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .stuff_en   (stuff_en),
    .se0        (se0),
    .force_j    (force_j),
    .bit_strobe (bit_strobe),
    .busy       (enc_busy),
    .d_plus     (d_plus),
    .d_minus    (d_minus)
  );

endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: expected line streams are hand-built bit lists
// (stuff bits written out explicitly) run through a small NRZI model.
module tb_usb_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] tx_packet = 3'd0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic [7:0] tx_packet_data = 8'h00;
  logic       get_tx_packet_data, d_plus, d_minus, tx_transfer_active, tx_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];
  logic [1:0] lvl;
  logic [7:0] buf_q[$];
  logic [1:0] samp[1000];

  always #5 clk = ~clk;

  usb_tx dut (
    .clk                (clk),
    .rst                (rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .d_plus             (d_plus),
    .d_minus            (d_minus),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // NRZI: 0 toggles the line, 1 holds it; bits taken LSB first
  task automatic push_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (!v[i]) lvl = ~lvl;
      exp_q.push_back(lvl);
    end
  endtask

  task automatic new_pkt();
    exp_q.delete();
    lvl = 2'b10;
    push_bits(16'h0080, 8);
  endtask

  task automatic push_eop();
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    lvl = 2'b10;
    exp_q.push_back(lvl);
  endtask

  task automatic run_pkt(input string tag, input logic [2:0] code, input logic [6:0] occ,
                         input int inj_at, input logic [2:0] inj_code,
                         input int exp_act, input int exp_pops, input int exp_errs);
    int n, act_n, pops, errs, bad;
    logic [7:0] dummy;
    n = 0; act_n = 0; pops = 0; errs = 0; bad = 0;
    @(negedge clk);
    buffer_occupancy = occ;
    tx_packet_data   = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
    tx_packet        = code;
    @(negedge clk);
    tx_packet = 3'd0;
    while (n < 1000 && tx_transfer_active) begin
      samp[n] = {d_plus, d_minus};
      act_n++;
      errs += int'(tx_error);
      tx_packet = (n == inj_at) ? inj_code : 3'd0;
      if (get_tx_packet_data) begin
        pops++;
        @(posedge clk);
        #1;
        if (buf_q.size() > 0) dummy = buf_q.pop_front();
        tx_packet_data = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
      end
      @(negedge clk);
      n++;
    end
    tx_packet = 3'd0;
    check({tag, "_active_clks"}, act_n, exp_act);
    check({tag, "_pops"}, pops, exp_pops);
    check({tag, "_errors"}, errs, exp_errs);
    for (int k = 0; k < exp_q.size(); k++)
      if (k * 8 + 3 < act_n)
        check($sformatf("%s_bit%0d", tag, k), samp[k * 8 + 3], exp_q[k]);
    for (int i = 0; i < act_n; i++)
      if (i / 8 >= exp_q.size() || samp[i] !== exp_q[i / 8]) bad++;
    check({tag, "_edge_timing"}, bad, 0);
    check({tag, "_idle_j"}, {d_plus, d_minus}, 2'b10);
  endtask

  task automatic err_pulse(input string tag, input logic [2:0] code);
    @(negedge clk);
    tx_packet = code;
    @(negedge clk);
    tx_packet = 3'd0;
    check({tag, "_err_hi"}, tx_error, 1'b1);
    check({tag, "_active"}, tx_transfer_active, 1'b0);
    @(negedge clk);
    check({tag, "_err_lo"}, tx_error, 1'b0);
    repeat (10) @(negedge clk);
    check({tag, "_lines_j"}, {d_plus, d_minus}, 2'b10);
    check({tag, "_still_idle"}, tx_transfer_active, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lines", {d_plus, d_minus}, 2'b10);
    check("rst_active", tx_transfer_active, 1'b0);
    check("rst_get", get_tx_packet_data, 1'b0);
    check("rst_err", tx_error, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_lines", {d_plus, d_minus}, 2'b10);

    // ACK: SYNC + 0xD2 + EOP = 19 bits
    new_pkt(); push_bits(16'h00D2, 8); push_eop();
    run_pkt("ack", 3'd3, 7'd0, -1, 3'd0, 152, 0, 0);

    // DATA1 zero length: CRC field is all zero bits
    new_pkt(); push_bits(16'h004B, 8); push_bits(16'h0000, 16); push_eop();
    run_pkt("zlp", 3'd2, 7'd0, -1, 3'd0, 280, 0, 0);

    // DATA0 FF FF: PID ends in two 1s, so stuffs fall after payload 1s 4, 10, 16,
    // then CRC (0xFFFF inverted from 0x0000) takes two more
    buf_q = '{8'hFF, 8'hFF};
    new_pkt(); push_bits(16'h00C3, 8);
    push_bits(16'h000F, 4); push_bits(16'h0, 1);
    repeat (4) begin push_bits(16'h003F, 6); push_bits(16'h0, 1); end
    push_bits(16'h000F, 4); push_eop();
    run_pkt("ffff", 3'd1, 7'd2, -1, 3'd0, 448, 2, 0);

    // DATA0 single 0x01, CRC field 0x7F81; ACK injected mid-packet must only raise tx_error
    buf_q = '{8'h01};
    new_pkt(); push_bits(16'h00C3, 8); push_bits(16'h0001, 8);
    push_bits(16'h0081, 8); push_bits(16'h001F, 5); push_bits(16'h0, 1);
    push_bits(16'h0003, 3); push_eop();
    run_pkt("one", 3'd1, 7'd1, 100, 3'd3, 352, 1, 1);

    err_pulse("bad7", 3'd7);

    // reset while in the DATA field
    buf_q.delete();
    @(negedge clk);
    tx_packet_data = 8'hFF; buffer_occupancy = 7'd2; tx_packet = 3'd1;
    @(negedge clk);
    tx_packet = 3'd0;
    repeat (200) @(negedge clk);
    check("mid_busy", tx_transfer_active, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_lines", {d_plus, d_minus}, 2'b10);
    check("mid_rst_active", tx_transfer_active, 1'b0);
    check("mid_rst_get", get_tx_packet_data, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    new_pkt(); push_bits(16'h00D2, 8); push_eop();
    run_pkt("ack2", 3'd3, 7'd0, -1, 3'd0, 152, 0, 0);

`ifdef USB_TX_STALL_EN
    new_pkt(); push_bits(16'h001E, 8); push_eop();
    run_pkt("stall", 3'd5, 7'd0, -1, 3'd0, 152, 0, 0);
`else
    err_pulse("stall_off", 3'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
